xif_offload_queue: RTL
======================

Name: xif_offload_queue

Overview:
- Coprocessor-side stage directly downstream of the CV-X-IF issue, register and commit channels.
- Accepts decoded offloaded instructions and pairs them with their source operands and commit/kill decisions.
- Releases non-speculative, fully-operanded instructions in issue order to the coprocessor execution unit; killed instructions are dropped silently.

Parameters:
- DEPTH, 4: number of in-flight entries; power of two, at least 2.
- X_NUM_RS, 2: source operands per instruction.
- X_ID_WIDTH, 4: width of the instruction id.
- X_HARTID_WIDTH, 1: width of the hart id.
- X_RFR_WIDTH, 32: operand width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  issue request ready.
- issue_instr_i  in  32  offloaded instruction.
- issue_id_i  in  X_ID_WIDTH  instruction id.
- issue_hartid_i  in  X_HARTID_WIDTH  hart id.
- dec_accept_i  in  1  external decoder accepts issue_instr_i.
- dec_rs_needed_i  in  X_NUM_RS  operands required by the instruction.
- issue_resp_accept_o  out  1  accept response, equal to dec_accept_i.
- register_valid_i  in  1  operand transaction valid.
- register_ready_o  out  1  operand transaction ready.
- register_id_i  in  X_ID_WIDTH  operand transaction id.
- register_rs_i  in  X_NUM_RS*X_RFR_WIDTH  operand values.
- register_rs_valid_i  in  X_NUM_RS  per-operand valid.
- commit_valid_i  in  1  commit transaction valid.
- commit_id_i  in  X_ID_WIDTH  committed id.
- commit_kill_i  in  1  kill flag.
- disp_valid_o  out  1  dispatch valid.
- disp_ready_i  in  1  execution unit ready.
- disp_instr_o  out  32  dispatched instruction.
- disp_id_o  out  X_ID_WIDTH  dispatched id.
- disp_hartid_o  out  X_HARTID_WIDTH  dispatched hart id.
- disp_rs_o  out  X_NUM_RS*X_RFR_WIDTH  dispatched operands.
- proto_err_o  out  1  sticky protocol-error flag.

Behaviour:
- Storage: circular buffer of DEPTH entries with wr_ptr, reg_ptr and rd_ptr, each log2(DEPTH)+1 bits, wrap-around by MSB toggle.
- Entry fields: valid, instr, id, hartid, rs, rs_needed, rs_got, committed, killed.
- Reset: all entries invalid, all pointers 0, proto_err_o=0, disp_valid_o=0, issue_ready_o=1 (empty), register_ready_o=0.
- Reset asserted mid-operation discards every entry with no dispatch.
- Issue:
  - issue_ready_o = !full; registered state only, no same-cycle dispatch bypass.
  - On handshake with dec_accept_i=1: allocate the entry at wr_ptr, set rs_got=0, increment wr_ptr.
  - On handshake with dec_accept_i=0: complete the handshake, allocate nothing.
- Register:
  - Transactions arrive in issue order and target the entry at reg_ptr.
  - register_ready_o = (reg_ptr != wr_ptr), or the same-cycle issue handshake is allocating into an empty register slot (bypass).
  - On handshake: rs_got |= register_rs_valid_i and rs lanes are written; reg_ptr advances once rs_got covers rs_needed.
  - Id mismatch against the target entry: proto_err_o set; data still written.
  - An entry with rs_needed=0 advances reg_ptr on allocation, without a register transaction.
- Commit:
  - Id is compared against all valid entries plus any entry allocated this cycle. The matching entry sets committed=1 and killed=commit_kill_i.
  - No match (rejected or unknown id): ignored.
  - Commit for an already-committed entry: proto_err_o set.
- Dispatch from head (rd_ptr):
  - disp_valid_o = head valid & committed & !killed & rs_needed covered by rs_got.
  - disp_* outputs are driven from head registers, giving a minimum of 1 cycle from the last of issue/register/commit.
  - disp_valid_o stays stable until disp_ready_i; on handshake the entry is freed and rd_ptr incremented.
  - A killed head is freed one entry per cycle with no dispatch, regardless of operand state. reg_ptr is advanced past it if pointing at it.
- Simultaneous events:
  - Issue and free in the same cycle: both take effect; the count is unchanged.
  - Commit and dispatch of the same id in the same cycle cannot occur, because dispatch needs committed already set.
- Full: issue_ready_o=0, and rises the cycle after a free. Empty: disp_valid_o=0.
- Ids are unique among in-flight entries; this is a host guarantee and is not checked.

Optional Feature:
- Macro: XIF_OFFLOAD_QUEUE_PERF_EN.
- Defined: adds 32-bit wrapping counters perf_accepted_o, perf_killed_o, perf_stall_o.
  - perf_accepted_o counts accepted issues.
  - perf_killed_o counts entries freed as killed.
  - perf_stall_o counts cycles with disp_valid_o & !disp_ready_i.
  - All counters reset to 0.
- Undefined: ports and counters are absent; functional behaviour is identical.

Test Plan:
- Basic flow: issue id=3 accept, same-cycle register rs={0x11,0x22}, commit id=3 kill=0 next cycle, disp_ready_i=1 -> disp_valid_o high the following cycle with disp_id_o=3, disp_rs_o={0x11,0x22}; the queue is empty afterwards.
- Reject: issue id=5 with dec_accept_i=0 -> handshake completes, issue_resp_accept_o=0, no allocation; a later commit id=5 is ignored and proto_err_o stays 0.
- Kill mid-queue: issue ids 1,2,3, commit 1 kill=0, 2 kill=1, 3 kill=0 -> dispatched ids are exactly 1 then 3; entry 2 is freed silently.
- Full backpressure: DEPTH=4 with disp_ready_i=0 and 4 accepted committed issues -> issue_ready_o=0; raising disp_ready_i for one cycle -> issue_ready_o=1 the next cycle; pointer wrap verified over 10 instructions.
- Protocol error: register transaction with id=7 while the head id is 6 -> proto_err_o=1 and stays set until reset.
- Async reset: assert rst_i with 3 entries pending -> outputs return to their reset values immediately; no dispatch after release.

Source files
------------

// File: rtl/xif_offload_queue.sv
// In-order offload queue pairing CV-X-IF issue, register and commit traffic ahead of execution.
// Optional performance counters are enabled by defining XIF_OFFLOAD_QUEUE_PERF_EN.
module xif_offload_queue #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned X_NUM_RS       = 2,
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_HARTID_WIDTH = 1,
    parameter int unsigned X_RFR_WIDTH    = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [31:0]                     issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]           issue_id_i,
    input  logic [X_HARTID_WIDTH-1:0]       issue_hartid_i,
    input  logic                            dec_accept_i,
    input  logic [X_NUM_RS-1:0]             dec_rs_needed_i,
    output logic                            issue_resp_accept_o,
    input  logic                            register_valid_i,
    output logic                            register_ready_o,
    input  logic [X_ID_WIDTH-1:0]           register_id_i,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] register_rs_i,
    input  logic [X_NUM_RS-1:0]             register_rs_valid_i,
    input  logic                            commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]           commit_id_i,
    input  logic                            commit_kill_i,
    output logic                            disp_valid_o,
    input  logic                            disp_ready_i,
    output logic [31:0]                     disp_instr_o,
    output logic [X_ID_WIDTH-1:0]           disp_id_o,
    output logic [X_HARTID_WIDTH-1:0]       disp_hartid_o,
    output logic [X_NUM_RS*X_RFR_WIDTH-1:0] disp_rs_o,
    output logic                            proto_err_o
`ifdef XIF_OFFLOAD_QUEUE_PERF_EN
    ,
    output logic [31:0]                     perf_accepted_o,
    output logic [31:0]                     perf_killed_o,
    output logic [31:0]                     perf_stall_o
`endif
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned RsW  = X_NUM_RS * X_RFR_WIDTH;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, reg_ptr_q, reg_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] valid_q, valid_d, committed_q, committed_d, killed_q, killed_d;
    logic proto_err_q, proto_err_d;

    logic [31:0]               instr_q     [DEPTH];
    logic [31:0]               instr_d     [DEPTH];
    logic [X_ID_WIDTH-1:0]     id_q        [DEPTH];
    logic [X_ID_WIDTH-1:0]     id_d        [DEPTH];
    logic [X_HARTID_WIDTH-1:0] hartid_q    [DEPTH];
    logic [X_HARTID_WIDTH-1:0] hartid_d    [DEPTH];
    logic [RsW-1:0]            rs_q        [DEPTH];
    logic [RsW-1:0]            rs_d        [DEPTH];
    logic [X_NUM_RS-1:0]       rs_needed_q [DEPTH];
    logic [X_NUM_RS-1:0]       rs_needed_d [DEPTH];
    logic [X_NUM_RS-1:0]       rs_got_q    [DEPTH];
    logic [X_NUM_RS-1:0]       rs_got_d    [DEPTH];

    logic [IdxW-1:0] wr_idx, reg_idx, rd_idx;
    logic full, issue_hs, alloc, reg_pending, bypass, reg_hs;
    logic cur_present, reg_advance, head_valid, head_covered, head_drop, disp_hs, free;
    logic [X_ID_WIDTH-1:0] cur_id;
    logic [X_NUM_RS-1:0] cur_needed, cur_got, got_next;

    assign wr_idx  = wr_ptr_q[IdxW-1:0];
    assign reg_idx = reg_ptr_q[IdxW-1:0];
    assign rd_idx  = rd_ptr_q[IdxW-1:0];

    assign full                = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) && (wr_idx == rd_idx);
    assign issue_ready_o       = !full;
    assign issue_resp_accept_o = dec_accept_i;
    assign issue_hs            = issue_valid_i && issue_ready_o;
    assign alloc               = issue_hs && dec_accept_i;

    // With nothing awaiting operands, the entry being allocated this cycle is the register target.
    assign reg_pending      = (reg_ptr_q != wr_ptr_q);
    assign bypass           = !reg_pending && alloc && (dec_rs_needed_i != '0);
    assign register_ready_o = reg_pending || bypass;
    assign reg_hs           = register_valid_i && register_ready_o;

    assign cur_present = reg_pending || alloc;
    assign cur_id      = reg_pending ? id_q[reg_idx] : issue_id_i;
    assign cur_needed  = reg_pending ? rs_needed_q[reg_idx] : dec_rs_needed_i;
    assign cur_got     = reg_pending ? rs_got_q[reg_idx] : '0;
    assign got_next    = cur_got | (reg_hs ? register_rs_valid_i : '0);

    assign head_valid   = valid_q[rd_idx];
    assign head_covered = (rs_got_q[rd_idx] & rs_needed_q[rd_idx]) == rs_needed_q[rd_idx];
    assign head_drop    = head_valid && committed_q[rd_idx] && killed_q[rd_idx];
    assign disp_valid_o = head_valid && committed_q[rd_idx] && !killed_q[rd_idx] && head_covered;
    assign disp_hs      = disp_valid_o && disp_ready_i;
    assign free         = disp_hs || head_drop;

    assign reg_advance = cur_present &&
        (((got_next & cur_needed) == cur_needed) || (head_drop && (reg_ptr_q == rd_ptr_q)));

    assign disp_instr_o  = instr_q[rd_idx];
    assign disp_id_o     = id_q[rd_idx];
    assign disp_hartid_o = hartid_q[rd_idx];
    assign disp_rs_o     = rs_q[rd_idx];
    assign proto_err_o   = proto_err_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        reg_ptr_d   = reg_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        killed_d    = killed_q;
        proto_err_d = proto_err_q;
        instr_d     = instr_q;
        id_d        = id_q;
        hartid_d    = hartid_q;
        rs_d        = rs_q;
        rs_needed_d = rs_needed_q;
        rs_got_d    = rs_got_q;

        if (alloc) begin
            valid_d[wr_idx]     = 1'b1;
            instr_d[wr_idx]     = issue_instr_i;
            id_d[wr_idx]        = issue_id_i;
            hartid_d[wr_idx]    = issue_hartid_i;
            rs_needed_d[wr_idx] = dec_rs_needed_i;
            rs_got_d[wr_idx]    = '0;
            committed_d[wr_idx] = 1'b0;
            killed_d[wr_idx]    = 1'b0;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
        end

        if (reg_hs) begin
            rs_got_d[reg_idx] = got_next;
            for (int unsigned l = 0; l < X_NUM_RS; l++) begin
                if (register_rs_valid_i[l]) begin
                    rs_d[reg_idx][l*X_RFR_WIDTH +: X_RFR_WIDTH] =
                        register_rs_i[l*X_RFR_WIDTH +: X_RFR_WIDTH];
                end
            end
            if (register_id_i != cur_id) proto_err_d = 1'b1;
        end

        if (reg_advance) reg_ptr_d = reg_ptr_q + PtrW'(1);

        // Post-allocation view so a commit can hit the entry allocated in the same cycle.
        if (commit_valid_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (valid_d[i] && (id_d[i] == commit_id_i)) begin
                    if (committed_d[i]) begin
                        proto_err_d = 1'b1;
                    end else begin
                        committed_d[i] = 1'b1;
                        killed_d[i]    = commit_kill_i;
                    end
                end
            end
        end

        if (free) begin
            valid_d[rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            reg_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            reg_ptr_q   <= reg_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
            killed_q    <= killed_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        instr_q     <= instr_d;
        id_q        <= id_d;
        hartid_q    <= hartid_d;
        rs_q        <= rs_d;
        rs_needed_q <= rs_needed_d;
        rs_got_q    <= rs_got_d;
    end

`ifdef XIF_OFFLOAD_QUEUE_PERF_EN
    logic [31:0] perf_accepted_q, perf_killed_q, perf_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_accepted_q <= '0;
            perf_killed_q   <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (alloc) perf_accepted_q <= perf_accepted_q + 32'd1;
            if (head_drop) perf_killed_q <= perf_killed_q + 32'd1;
            if (disp_valid_o && !disp_ready_i) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_accepted_o = perf_accepted_q;
    assign perf_killed_o   = perf_killed_q;
    assign perf_stall_o    = perf_stall_q;
`endif

endmodule
